// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit (AND/OR/XOR/NOR) feeding a DEPTH-entry result FIFO.
// Define LOGIC_UNIT_ZERO_FLAG_EN to add a per-entry all-zero flag on out_zero.
module logic_unit_pipe #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               op,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    output logic                     out_zero,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] res;
    logic             push, pop;

    always_comb begin
        res = '0;
        case (op)
            2'b00:   res = a & b;
            2'b01:   res = a | b;
            2'b10:   res = a ^ b;
            default: res = ~(a | b);
        endcase
    end

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count_q != CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign out_data  = out_valid ? mem_q[head_q] : '0;
    assign count     = count_q;

    always_comb begin
        head_d  = pop  ? head_q + PW'(1) : head_q;
        tail_d  = push ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; writes are suppressed on the reset edge.
    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem_q[tail_q] <= res;
    end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    logic zf_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst_n && push)
            zf_q[tail_q] <= (res == '0);
    end

    assign out_zero = out_valid & zf_q[head_q];
`endif

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 64: operand and result width in bits, legal range 1..64.
REQ-002 SHALL have parameter DEPTH, default 2: result FIFO entries, power of 2, legal range 2..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1: operand set offered.
REQ-006 SHALL have port in_ready, output, 1: block accepts an operand set this cycle.
REQ-007 SHALL have port op, input, 2: operation select, encoded 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-008 SHALL have port a, input, WIDTH: operand A.
REQ-009 SHALL have port b, input, WIDTH: operand B.
REQ-010 SHALL have port out_valid, output, 1: result available at the FIFO head.
REQ-011 SHALL have port out_ready, input, 1: consumer takes the head result.
REQ-012 SHALL have port out_data, output, WIDTH: head result.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1: number of FIFO entries.

Function
REQ-014 SHALL count an input transfer on a rising edge where in_valid=1 and in_ready=1; a, b and op SHALL be sampled only on that edge.
REQ-015 SHALL compute the bitwise result over all WIDTH bits per op: a&b, a|b, a^b or ~(a|b).
REQ-016 SHALL write the result into the FIFO tail on the transfer edge, with out_valid=1 for that entry from the next cycle (latency 1 cycle when the FIFO was empty).
REQ-017 SHALL drive in_ready = (count != DEPTH), combinationally from registered state only, with no dependence on out_ready.
REQ-018 SHALL count an output transfer on a rising edge where out_valid=1 and out_ready=1, then advance the head.
REQ-019 SHALL drive out_valid = (count != 0).
REQ-020 SHALL drive out_data with the head entry while out_valid=1, and with all-zero otherwise.
REQ-021 SHALL, on a simultaneous input and output transfer, keep count unchanged and advance both head and tail.
REQ-022 SHALL wrap the head and tail pointers modulo DEPTH with no lost or duplicated entry.
REQ-023 SHALL deliver results strictly in acceptance order.
REQ-024 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-025 SHALL ignore a, b and op when in_valid=0 or in_ready=0.

Reset
REQ-026 SHALL, on a rising edge with rst_n=0, clear count, head and tail to 0, giving in_ready=1, out_valid=0 and out_data=0 from the following cycle.
REQ-027 SHALL discard all entries on a reset mid-operation and ignore any handshake on the reset edge.
REQ-028 SHALL NOT require FIFO storage to be reset.

Configuration
REQ-029 SHALL, with macro LOGIC_UNIT_ZERO_FLAG_EN defined, add output port out_zero (1 bit), stored per entry and equal to 1 when the head result is all-zero, and forced to 0 when out_valid=0.
REQ-030 SHALL, without LOGIC_UNIT_ZERO_FLAG_EN, have no out_zero port and no associated storage, with all other behaviour identical.

Verification
REQ-031 SHALL pass this scenario: WIDTH=64, op=01, a=0xF0F0_0000_0000_000F, b=0x0F0F_0000_0000_00F0, out_ready=1 -> out_valid next cycle with out_data=0xFFFF_0000_0000_00FF.
REQ-032 SHALL pass this scenario: one beat each of op 00/10/11 with a=0xFF00, b=0x0FF0 and WIDTH=16 -> outputs 0x0F00, 0xF0F0, 0x000F in order.
REQ-033 SHALL pass this scenario: DEPTH=2, out_ready=0, three back-to-back offers -> count=2, in_ready=0 after two accepts, third held; when out_ready=1 the three results drain in order.
REQ-034 SHALL pass this scenario: FIFO at count=1 with in_valid=1 and out_ready=1 for 10 cycles -> count stays 1 and pointers wrap without a lost or duplicated result.
REQ-035 SHALL pass this scenario: count=2, then rst_n=0 for one edge -> next cycle count=0, out_valid=0, out_data=0, in_ready=1.
REQ-036 SHALL pass this scenario: with LOGIC_UNIT_ZERO_FLAG_EN defined, op=00, a=0xAAAA, b=0x5555 -> out_data=0, out_zero=1; op=01 with the same operands -> out_data=0xFFFF, out_zero=0.
